// File: rtl/sw_reader_pkg.sv
// ============================================================================
// Module  : sw_reader_pkg
// Purpose : Shared types and helpers for the operand switch reader.
//           - btn_state_e : debounce state of the operation button
//           - cnt_width() : bit width of a counter able to hold 0..cycles
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package sw_reader_pkg;

  // Button debounce states. RELEASED/PRESS_WAIT see a debounced 0,
  // PRESSED/RELEASE_WAIT see a debounced 1.
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Width of a counter that must reach the value 'cycles'.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sw_sync_debounce.sv
// ============================================================================
// Module  : sw_sync_debounce
// Purpose : Two-flop synchronizer followed by a vector-level debouncer.
//           The stable register only takes a new value once the same
//           differing synchronized value has been seen DEBOUNCE_CYCLES
//           consecutive cycles.
// Ports   : clock    in   system clock, rising edge
//           reset_n  in   asynchronous active-low reset
//           d_i      in   asynchronous input vector
//           sync_o   out  synchronized (not debounced) vector
//           stable_o out  debounced vector
//           settle_o out  high in the cycle whose rising edge loads stable_o
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sw_sync_debounce
  import sw_reader_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] stable_o,
  output logic             settle_o
);

  localparam int            CW    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             w_diff;
  logic             w_same;
  logic [CW-1:0]    w_inc;
  logic             w_settle;

  always_comb begin
    w_diff   = (sync_q != stable_q);
    // The run only continues while the differing value is the one being
    // counted; any other differing value restarts the run at one.
    w_same   = (cnt_q != '0) && (sync_q == cand_q);
    w_inc    = w_same ? (cnt_q + ONE) : ONE;
    w_settle = w_diff && (w_inc == LIMIT);

    stable_d = w_settle ? sync_q : stable_q;
    cnt_d    = (w_diff && !w_settle) ? w_inc : '0;
    cand_d   = w_diff ? sync_q : cand_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      stable_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= d_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sync_o   = sync_q;
  assign stable_o = stable_q;
  assign settle_o = w_settle;

endmodule

`default_nettype wire

// File: rtl/sw_operand_reader.sv
// ============================================================================
// Module  : sw_operand_reader
// Purpose : Reads four operand switches and the operation button, debounces
//           them, and on each debounced press (with enable) captures the
//           switch vector into a valid/ready operand slot.
// Ports   : clock      in   system clock, rising edge
//           reset_n    in   asynchronous active-low reset
//           SW1..SW4   in   asynchronous switch levels (SW4 = MSB)
//           operation  in   asynchronous button, active high
//           enable     in   synchronous capture enable
//           ready      in   CPU accepts operand when valid && ready
//           sw_value   out  live debounced switch vector
//           operand    out  captured operand, stable while valid
//           valid      out  operand pending
//           overrun    out  sticky: press arrived while operand pending
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sw_operand_reader
  import sw_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       SW4,
  input  logic       operation,
  input  logic       enable,
  input  logic       ready,
  output logic [3:0] sw_value,
  output logic [3:0] operand,
  output logic       valid,
  output logic       overrun
);

  // --------------------------------------------------------------------------
  // Switch path: synchronize and debounce the whole vector together.
  // --------------------------------------------------------------------------
  logic [3:0] w_sw_sync;
  logic [3:0] w_sw_stable;
  logic       w_sw_settle;

  sw_sync_debounce #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clock    (clock),
    .reset_n  (reset_n),
    .d_i      ({SW4, SW3, SW2, SW1}),
    .sync_o   (w_sw_sync),
    .stable_o (w_sw_stable),
    .settle_o (w_sw_settle)
  );

  // Only the stable vector is needed from the switch path.
  logic w_unused_sw;
  assign w_unused_sw = &{1'b0, w_sw_sync, w_sw_settle};

  // --------------------------------------------------------------------------
  // Button path: the shared debouncer supplies the synchronized level and
  // the settle strobe; the FSM turns the 0->1 settle into a press pulse.
  // --------------------------------------------------------------------------
  logic [0:0] w_btn_sync;
  logic [0:0] w_btn_stable;
  logic       w_btn_settle;

  sw_sync_debounce #(
    .WIDTH           (1),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clock    (clock),
    .reset_n  (reset_n),
    .d_i      (operation),
    .sync_o   (w_btn_sync),
    .stable_o (w_btn_stable),
    .settle_o (w_btn_settle)
  );

  btn_state_e state_q;
  logic       press_q;

  // The debouncer's counter runs exactly while the FSM is in a *_WAIT
  // state, so its settle strobe marks the end of each wait.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RELEASED;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (w_btn_sync[0]) begin
            // With a one-cycle debounce the first sample already settles.
            if (w_btn_settle) begin
              state_q <= PRESSED;
              press_q <= 1'b1;
            end else begin
              state_q <= PRESS_WAIT;
            end
          end
        end
        PRESS_WAIT: begin
          if (!w_btn_sync[0]) begin
            state_q <= RELEASED;
          end else if (w_btn_settle && !w_btn_stable[0]) begin
            state_q <= PRESSED;
            press_q <= 1'b1;
          end
        end
        PRESSED: begin
          if (!w_btn_sync[0]) begin
            state_q <= w_btn_settle ? RELEASED : RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (w_btn_sync[0]) begin
            state_q <= PRESSED;
          end else if (w_btn_settle && w_btn_stable[0]) begin
            state_q <= RELEASED;
          end
        end
        default: state_q <= RELEASED;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Operand slot. A press in the same cycle as a handshake refills the slot
  // without a bubble; a press into a full, unaccepted slot is an overrun.
  // The press uses the sw_value of its own cycle.
  // --------------------------------------------------------------------------
  logic [3:0] operand_q;
  logic       valid_q;
  logic       overrun_q;
  logic       w_capture;

  assign w_capture = press_q && enable;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      operand_q <= 4'h0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (w_capture) begin
      if (!valid_q || ready) begin
        operand_q <= w_sw_stable;
        valid_q   <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end
  end

  assign sw_value = w_sw_stable;
  assign operand  = operand_q;
  assign valid    = valid_q;
  assign overrun  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_sw_operand_reader.sv
// ============================================================================
// Module  : tb_sw_operand_reader
// Purpose : Self-checking bench for sw_operand_reader. A run-length model of
//           synchronizer + debounce + operand slot is compared with the DUT
//           every cycle; directed scenarios add literal expectations.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sw_operand_reader;

  localparam int D = 4;

  logic       clock     = 1'b0;
  logic       reset_n   = 1'b0;
  logic       SW1       = 1'b0;
  logic       SW2       = 1'b0;
  logic       SW3       = 1'b0;
  logic       SW4       = 1'b0;
  logic       operation = 1'b0;
  logic       enable    = 1'b0;
  logic       ready     = 1'b0;
  logic [3:0] sw_value;
  logic [3:0] operand;
  logic       valid;
  logic       overrun;

  int   n_vec   = 0;
  int   n_err   = 0;
  logic cmp_en  = 1'b0;
  int   sw_hold = 0;
  int   op_hold = 0;

  sw_operand_reader #(
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .SW1       (SW1),
    .SW2       (SW2),
    .SW3       (SW3),
    .SW4       (SW4),
    .operation (operation),
    .enable    (enable),
    .ready     (ready),
    .sw_value  (sw_value),
    .operand   (operand),
    .valid     (valid),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  // --------------------------------------------------------------------------
  // Behavioural model: inputs reach the debouncer two edges late; a level is
  // adopted once the same value has been seen D times in a row while it
  // differs from the debounced value. A press is a 0->1 debounced button.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] deb;
    logic [3:0] run_val;
    int         run;
    logic       b1;
    logic       b2;
    logic       bdeb;
    logic       brv;
    int         brun;
    logic       press;
    logic [3:0] operand;
    logic       valid;
    logic       overrun;
  } model_t;

  model_t m;

  function automatic model_t step(model_t c, logic [3:0] sw, logic op,
                                  logic en, logic rdy);
    model_t n = c;
    if (c.press && en) begin
      if (!c.valid || rdy) begin
        n.operand = c.deb;
        n.valid   = 1'b1;
      end else begin
        n.overrun = 1'b1;
      end
    end else if (c.valid && rdy) begin
      n.valid = 1'b0;
    end

    if (c.s2 == c.run_val) n.run = (c.run < 64) ? c.run + 1 : 64;
    else begin n.run_val = c.s2; n.run = 1; end
    if (c.s2 != c.deb && n.run >= D) n.deb = c.s2;
    n.s2 = c.s1;
    n.s1 = sw;

    if (c.b2 == c.brv) n.brun = (c.brun < 64) ? c.brun + 1 : 64;
    else begin n.brv = c.b2; n.brun = 1; end
    if (c.b2 != c.bdeb && n.brun >= D) n.bdeb = c.b2;
    n.press = !c.bdeb && n.bdeb;
    n.b2 = c.b1;
    n.b1 = op;
    return n;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m <= '0;
    else          m <= step(m, {SW4, SW3, SW2, SW1}, operation, enable, ready);
  end

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {3'b000, act}, {3'b000, exp});
  endtask

  always @(negedge clock) begin
    if (reset_n && cmp_en) begin
      chk ("cmp_sw_value", sw_value, m.deb);
      chk ("cmp_operand",  operand,  m.operand);
      chk1("cmp_valid",    valid,    m.valid);
      chk1("cmp_overrun",  overrun,  m.overrun);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_sw(input logic [3:0] v);
    {SW4, SW3, SW2, SW1} = v;
  endtask

  task automatic press(input int n);
    operation = 1'b1;
    cyc(n);
    operation = 1'b0;
    cyc(12);
  endtask

  initial begin
    // Reset with all inputs active.
    set_sw(4'hF); operation = 1'b1; enable = 1'b1; ready = 1'b0;
    reset_n = 1'b0;
    cyc(3);
    chk ("rst_sw_value", sw_value, 4'h0);
    chk ("rst_operand",  operand,  4'h0);
    chk1("rst_valid",    valid,    1'b0);
    chk1("rst_overrun",  overrun,  1'b0);
    reset_n = 1'b1; cmp_en = 1'b1;
    cyc(5); chk("rst_sw_not_yet", sw_value, 4'h0);
    cyc(1); chk("rst_sw_settled", sw_value, 4'hF); chk1("rst_valid_not_yet", valid, 1'b0);
    cyc(1); chk1("rst_held_press", valid, 1'b1); chk("rst_operand_F", operand, 4'hF);
    ready = 1'b1; cyc(1); ready = 1'b0;
    chk1("rst_hs_valid", valid, 1'b0); chk("rst_hs_operand", operand, 4'hF);
    operation = 1'b0; cyc(12);

    // Basic capture: valid rises 6 edges after first sampling edge.
    set_sw(4'hA); cyc(8);
    chk("cap_sw_A", sw_value, 4'hA);
    operation = 1'b1;
    cyc(6); chk1("cap_valid_early", valid, 1'b0);
    cyc(1); chk1("cap_valid", valid, 1'b1); chk("cap_operand", operand, 4'hA);
    chk("model_operand_A", m.operand, 4'hA);
    cyc(3); operation = 1'b0; ready = 1'b1;
    cyc(1); ready = 1'b0;
    chk1("cap_hs_valid", valid, 1'b0); chk("cap_hs_operand", operand, 4'hA);
    cyc(12);

    // Bounce rejection on button and switches.
    repeat (4) begin
      operation = 1'b1; cyc(3); operation = 1'b0; cyc(3);
    end
    cyc(10); chk1("bounce_btn_valid", valid, 1'b0);
    set_sw(4'h3); cyc(3); set_sw(4'hA); cyc(10);
    chk("bounce_sw_value", sw_value, 4'hA);

    // Overrun.
    set_sw(4'h5); cyc(8); press(10);
    chk1("ovr_first_valid", valid, 1'b1); chk("ovr_first_operand", operand, 4'h5);
    chk1("ovr_first_flag", overrun, 1'b0);
    set_sw(4'h6); cyc(8); press(10);
    chk("ovr_operand_kept", operand, 4'h5); chk1("ovr_flag", overrun, 1'b1);
    chk1("model_overrun", m.overrun, 1'b1);
    ready = 1'b1; cyc(1); ready = 1'b0;
    chk1("ovr_hs_valid", valid, 1'b0); chk1("ovr_sticky", overrun, 1'b1);

    // Reset with an operand pending.
    press(10);
    chk1("midrst_pending", valid, 1'b1);
    reset_n = 1'b0; cyc(2);
    chk1("midrst_valid", valid, 1'b0); chk1("midrst_overrun", overrun, 1'b0);
    chk("midrst_operand", operand, 4'h0);
    reset_n = 1'b1; cyc(10);

    // Capture coincident with handshake.
    set_sw(4'h2); cyc(8); press(10);
    chk("sim_first_operand", operand, 4'h2);
    set_sw(4'h9); cyc(8);
    operation = 1'b1; cyc(6); ready = 1'b1; cyc(1); ready = 1'b0;
    chk1("sim_valid", valid, 1'b1); chk("sim_operand", operand, 4'h9);
    chk1("sim_overrun", overrun, 1'b0);
    cyc(4); operation = 1'b0; cyc(12);

    // Press with enable low is discarded.
    ready = 1'b1; cyc(1); ready = 1'b0;
    set_sw(4'hC); cyc(8); enable = 1'b0; press(10);
    chk1("en0_valid", valid, 1'b0);
    enable = 1'b1; cyc(10);
    chk1("en0_later_valid", valid, 1'b0); chk1("en0_overrun", overrun, 1'b0);
    press(10);
    chk1("en1_valid", valid, 1'b1); chk("en1_operand", operand, 4'hC);
    ready = 1'b1; cyc(1); ready = 1'b0;

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      if (sw_hold == 0) begin
        set_sw(4'($urandom_range(0, 15)));
        sw_hold = $urandom_range(1, 12);
      end
      sw_hold--;
      if (op_hold == 0) begin
        operation = ~operation;
        op_hold = $urandom_range(1, 12);
      end
      op_hold--;
      enable  = ($urandom_range(0, 7) != 0);
      ready   = ($urandom_range(0, 2) == 0);
      reset_n = ($urandom_range(0, 999) != 0);
      cyc(1);
    end
    reset_n = 1'b1;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
